dmem_arbiter: RTL and testbench

//  Two-master arbiter for the single-port data_mem. M0 is the core ex-stage load/store port; M1 is a

---
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/dmem_arbiter.sv | 65 ++++++
 tb/tb_dmem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: M0/M1 request ports and data_mem port bundled for dmem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          m0_req_i;
   logic          m0_we_i;
   logic [AW-1:0] m0_addr_i;
   logic [DW-1:0] m0_wdata_i;
   logic          m0_gnt_o;
   logic          m0_rvalid_o;
   logic [DW-1:0] m0_rdata_o;
   logic          m1_req_i;
   logic          m1_we_i;
   logic [AW-1:0] m1_addr_i;
   logic [DW-1:0] m1_wdata_i;
   logic          m1_gnt_o;
   logic          m1_rvalid_o;
   logic [DW-1:0] m1_rdata_o;
   logic          s_req_o;
   logic          s_we_o;
   logic [AW-1:0] s_addr_o;
   logic [DW-1:0] s_wdata_o;
   logic [DW-1:0] s_rdata_i;
   logic          hold_flag_o;
   modport slave (
      input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
      input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, s_rdata_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      output s_req_o, s_we_o, s_addr_o, s_wdata_o, hold_flag_o
   );
   modport master (
      output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
      output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, s_rdata_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      input  s_req_o, s_we_o, s_addr_o, s_wdata_o, hold_flag_o
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for single-port data_mem with one-cycle read return.
// DMEM_ARB_RR_EN selects round-robin with MAX_BURST limit; otherwise M0 has fixed priority.
module dmem_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {SEL_NONE, SEL_M0, SEL_M1} sel_t;
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] CNT_MAX = BW'(MAX_BURST - 1);
   sel_t          r_owner, r_last, r_rsel, w_gnt;
   logic [BW-1:0] r_cnt;
   logic          w_acc, w_g0, w_g1, w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   always_comb begin
      w_gnt = SEL_NONE;
`ifdef DMEM_ARB_RR_EN
      w_gnt = (r_owner == SEL_M0 && bus.m0_req_i) ?
                 ((bus.m1_req_i && r_cnt == CNT_MAX) ? SEL_M1 : SEL_M0) :
              (r_owner == SEL_M1 && bus.m1_req_i) ?
                 ((bus.m0_req_i && r_cnt == CNT_MAX) ? SEL_M0 : SEL_M1) :
              (bus.m0_req_i && bus.m1_req_i) ? ((r_last == SEL_M0) ? SEL_M1 : SEL_M0) :
              bus.m0_req_i ? SEL_M0 :
              bus.m1_req_i ? SEL_M1 : SEL_NONE;
`else
      w_gnt = bus.m0_req_i ? SEL_M0 : bus.m1_req_i ? SEL_M1 : SEL_NONE;
`endif
   end
   assign w_g0    = (w_gnt == SEL_M0);
   assign w_g1    = (w_gnt == SEL_M1);
   assign w_acc   = w_g0 | w_g1;
   assign w_we    = w_g0 ? bus.m0_we_i    : w_g1 ? bus.m1_we_i    : 1'b0;
   assign w_addr  = w_g0 ? bus.m0_addr_i  : w_g1 ? bus.m1_addr_i  : '0;
   assign w_wdata = w_g0 ? bus.m0_wdata_i : w_g1 ? bus.m1_wdata_i : '0;
   assign bus.m0_gnt_o    = w_g0;
   assign bus.m1_gnt_o    = w_g1;
   assign bus.s_req_o     = w_acc;
   assign bus.s_we_o      = w_we;
   assign bus.s_addr_o    = w_addr;
   assign bus.s_wdata_o   = w_wdata;
   assign bus.hold_flag_o = bus.m0_req_i & ~w_g0;
   assign bus.m0_rvalid_o = (r_rsel == SEL_M0);
   assign bus.m1_rvalid_o = (r_rsel == SEL_M1);
   assign bus.m0_rdata_o  = (r_rsel == SEL_M0) ? bus.s_rdata_i : '0;
   assign bus.m1_rdata_o  = (r_rsel == SEL_M1) ? bus.s_rdata_i : '0;
   // owner falls back to NONE on any idle cycle, which also clears the burst count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner <= SEL_NONE;
         r_cnt   <= '0;
         r_last  <= SEL_M1;
         r_rsel  <= SEL_NONE;
      end else begin
         r_owner <= w_gnt;
         r_cnt   <= (!w_acc || w_gnt != r_owner) ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
         r_last  <= w_acc ? w_gnt : r_last;
         r_rsel  <= (w_acc && !w_we) ? w_gnt : SEL_NONE;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a small data_mem model.
// Expectations follow the build's arbitration mode (DMEM_ARB_RR_EN).
module tb_dmem_arbiter;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [31:0] mem [0:255];
   dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
   dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (rst) mem[64] <= 32'hDEADBEEF;
      else if (bus.s_req_o && bus.s_we_o) mem[bus.s_addr_o[9:2]] <= bus.s_wdata_o;
      if (bus.s_req_o && !bus.s_we_o) bus.s_rdata_i <= mem[bus.s_addr_o[9:2]];
   end
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask
   task automatic drv(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
      bus.m0_req_i = r0; bus.m0_we_i = w0; bus.m0_addr_i = a0; bus.m0_wdata_i = d0;
      bus.m1_req_i = r1; bus.m1_we_i = w1; bus.m1_addr_i = a1; bus.m1_wdata_i = d1;
      #2;
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [3:0] e0;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      chk("rst_sreq", {31'd0, bus.s_req_o}, 0);
      chk("rst_hold", {31'd0, bus.hold_flag_o}, 0);
      chk("rst_gnt", {30'd0, bus.m1_gnt_o, bus.m0_gnt_o}, 0);
      chk("rst_rvalid", {30'd0, bus.m1_rvalid_o, bus.m0_rvalid_o}, 0);
      chk("rst_rdata", bus.m0_rdata_o | bus.m1_rdata_o, 0);
      chk("rst_saddr", bus.s_addr_o, 0);
      cyc();
      drv(1, 0, 32'h100, 0, 0, 0, 0, 0);
      chk("rd_gnt0", {31'd0, bus.m0_gnt_o}, 1);
      chk("rd_saddr", bus.s_addr_o, 32'h100);
      chk("rd_swe", {31'd0, bus.s_we_o}, 0);
      chk("rd_hold", {31'd0, bus.hold_flag_o}, 0);
      cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rd_rvalid0", {31'd0, bus.m0_rvalid_o}, 1);
      chk("rd_rdata0", bus.m0_rdata_o, 32'hDEADBEEF);
      chk("rd_rvalid1", {31'd0, bus.m1_rvalid_o}, 0);
      cyc();
      chk("rd_rvalid_drop", {31'd0, bus.m0_rvalid_o}, 0);
      drv(0, 0, 0, 0, 1, 1, 32'h200, 32'h12345678);
      chk("wr_gnt1", {31'd0, bus.m1_gnt_o}, 1);
      chk("wr_swe", {31'd0, bus.s_we_o}, 1);
      chk("wr_swdata", bus.s_wdata_o, 32'h12345678);
      chk("wr_saddr", bus.s_addr_o, 32'h200);
      cyc();
      drv(1, 0, 32'h200, 0, 0, 0, 0, 0);
      chk("wr_no_rvalid", {31'd0, bus.m1_rvalid_o}, 0);
      chk("raw_gnt0", {31'd0, bus.m0_gnt_o}, 1);
      cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("raw_rvalid0", {31'd0, bus.m0_rvalid_o}, 1);
      chk("raw_rdata0", bus.m0_rdata_o, 32'h12345678);
      cyc();
      drv(1, 0, 32'h200, 0, 0, 0, 0, 0);
      chk("rstmid_gnt0", {31'd0, bus.m0_gnt_o}, 1);
      rst = 1'b1;
      cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rstmid_rvalid0", {31'd0, bus.m0_rvalid_o}, 0);
      chk("rstmid_rdata0", bus.m0_rdata_o, 0);
      rst = 1'b0;
      cyc();
      cyc();
      drv(1, 0, 32'h100, 0, 1, 0, 32'h200, 0);
      chk("both_gnt0", {31'd0, bus.m0_gnt_o}, 1);
      chk("both_gnt1", {31'd0, bus.m1_gnt_o}, 0);
      chk("both_hold", {31'd0, bus.hold_flag_o}, 0);
      cyc();
      drv(0, 0, 0, 0, 1, 0, 32'h200, 0);
      chk("both_gnt1_next", {31'd0, bus.m1_gnt_o}, 1);
      chk("both_rdata0", bus.m0_rdata_o, 32'hDEADBEEF);
      cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("both_rvalid1", {31'd0, bus.m1_rvalid_o}, 1);
      chk("both_rdata1", bus.m1_rdata_o, 32'h12345678);
      chk("both_rvalid0_off", {31'd0, bus.m0_rvalid_o}, 0);
      cyc();
      drv(0, 0, 0, 0, 1, 0, 32'h200, 0);
      chk("burst_pre_gnt1", {31'd0, bus.m1_gnt_o}, 1);
`ifdef DMEM_ARB_RR_EN
      e0 = 4'b1000;
`else
      e0 = 4'b1111;
`endif
      for (int i = 0; i < 4; i++) begin
         cyc();
         drv(1, 0, 32'h100, 0, 1, 0, 32'h200, 0);
         chk($sformatf("burst_gnt0_%0d", i), {31'd0, bus.m0_gnt_o}, {31'd0, e0[i]});
         chk($sformatf("burst_gnt1_%0d", i), {31'd0, bus.m1_gnt_o}, {31'd0, !e0[i]});
         chk($sformatf("burst_hold_%0d", i), {31'd0, bus.hold_flag_o}, {31'd0, !e0[i]});
      end
      cyc();
      drv(0, 0, 0, 0, 1, 0, 32'h200, 0);
      chk("burst_m1_after", {31'd0, bus.m1_gnt_o}, 1);
      chk("burst_rvalid0", {31'd0, bus.m0_rvalid_o}, 1);
      chk("burst_rdata0", bus.m0_rdata_o, 32'hDEADBEEF);
      cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("burst_rvalid1", {31'd0, bus.m1_rvalid_o}, 1);
      chk("burst_rdata1", bus.m1_rdata_o, 32'h12345678);
      chk("burst_idle_sreq", {31'd0, bus.s_req_o}, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
